// File: rtl/proc_pkg.sv
// Shared fetch-interface types and constants used by the instruction memory
// responder and the fetch stage.
package proc_pkg;

  localparam int WORD_BYTES   = 4;
  localparam int INSTR_W      = 32;
  localparam int FETCH_ADDR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0]      data;
    logic [FETCH_ADDR_W-1:0] addr;
    logic                    err;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// Small response FIFO with synchronous reset and clear; depth need not be a
// power of two, so pointers wrap explicitly.
module rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
  endfunction

  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == CNT_W'(0));
  assign count    = count_r;
  assign push_s   = push & ~full;
  assign pop_s    = pop & ~empty;
  assign pop_data = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction-fetch interface: fixed-latency word reads,
// credit-limited response queue, error reporting, flush and preload port.
module imem_responder
  import proc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int CAP   = LATENCY + 1;
  localparam int CNT_W = $clog2(CAP + 1);

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              req_ready_r;
  logic              accept_s;
  logic              pop_s;
  logic              err_s;
  fetch_rsp_t        new_ent_s;
  fetch_rsp_t        push_ent_s;
  logic              push_v_s;
  fetch_rsp_t        head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [$clog2(CAP+1)-1:0] fifo_count_s;
  logic              unused_ok_s;

  assign req_ready   = req_ready_r;
  assign accept_s    = req_valid & req_ready_r;
  assign rsp_valid   = ~fifo_empty_s;
  assign pop_s       = rsp_valid & rsp_ready;
  assign err_s       = (req_addr[1:0] != 2'b00) | (|req_addr[ADDR_W-1:IDX_W+2]);
  assign unused_ok_s = ^{fifo_count_s, fifo_full_s};

  // Build the entry for the request presented this cycle (read-before-write).
  always_comb begin
    new_ent_s      = '0;
    new_ent_s.addr = FETCH_ADDR_W'(req_addr);
    new_ent_s.err  = err_s;
    if (err_s) begin
      new_ent_s.data = INSTR_W'(0);
    end else begin
      new_ent_s.data = INSTR_W'(mem_r[req_addr[IDX_W+1:2]]);
    end
  end

  // Preload port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem_r[ld_addr] <= ld_data;
  end

  // The FIFO write is the final latency stage, so only LATENCY-1 registers precede it.
  if (LATENCY == 1) begin : g_direct
    assign push_v_s   = accept_s & ~flush;
    assign push_ent_s = new_ent_s;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_r;
    fetch_rsp_t         pd_r [LATENCY-1];

    // Valid bits of the non-stalling latency pipeline.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        pv_r <= '0;
      end else begin
        pv_r[0] <= accept_s;
        for (int i = 1; i < LATENCY - 1; i++) pv_r[i] <= pv_r[i-1];
      end
    end

    // Payload of the latency pipeline, qualified by pv_r.
    always_ff @(posedge clk) begin
      pd_r[0] <= new_ent_s;
      for (int i = 1; i < LATENCY - 1; i++) pd_r[i] <= pd_r[i-1];
    end

    assign push_v_s   = pv_r[LATENCY-2];
    assign push_ent_s = pd_r[LATENCY-2];
  end

  rsp_fifo #(
    .DEPTH (CAP),
    .WIDTH ($bits(fetch_rsp_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push_v_s),
    .push_data (push_ent_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Credit count covers pipeline plus queued entries.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = CNT_W'(0);
    end else begin
      count_next_s = count_r + CNT_W'(accept_s) - CNT_W'(pop_s);
    end
  end

  // Registered credit state; req_ready is precomputed from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= CNT_W'(0);
      req_ready_r <= 1'b1;
    end else begin
      count_r     <= count_next_s;
      req_ready_r <= (count_next_s < CNT_W'(CAP));
    end
  end

  // Present the FIFO head, forced to zero while nothing is valid.
  always_comb begin
    rsp_data = '0;
    rsp_addr = '0;
    rsp_err  = 1'b0;
    if (rsp_valid) begin
      rsp_data = DATA_W'(head_s.data);
      rsp_addr = ADDR_W'(head_s.addr);
      rsp_err  = head_s.err;
    end else begin
      rsp_data = '0;
      rsp_addr = '0;
      rsp_err  = 1'b0;
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the instruction-fetch request/response interface.
- Accepts word-fetch requests from the fetch stage and returns instruction words after a fixed LATENCY.
- Uses a credit-limited response queue, reports misaligned or out-of-range addresses, and supports a pipeline flush on branch redirect.
- Includes a write port so the program image can be preloaded.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, instruction word width.
- DEPTH_WORDS, 256, memory size in words (power of 2).
- LATENCY, 2, cycles from request accept to earliest response (legal 1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address of the instruction.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  fetch stage accepts the response.
- rsp_data  out  DATA_W  instruction word (0 when rsp_err).
- rsp_addr  out  ADDR_W  echo of the request address.
- rsp_err  out  1  misaligned or out-of-range fetch.
- flush  in  1  discard all in-flight and queued responses.
- ld_en  in  1  preload write enable.
- ld_addr  in  log2(DEPTH_WORDS)  preload word index.
- ld_data  in  DATA_W  preload word.

Behaviour:
- Reset (synchronous, active-high on rst at clk edge):
  - rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, req_ready=1.
  - All pipeline valid bits and the queue are cleared; the occupancy count is set to 0.
  - Memory contents are not cleared.
  - Reset asserted mid-transaction drops everything; no response for pre-reset requests ever appears.
- Accept and pop:
  - A request is accepted when req_valid & req_ready at a clk edge.
  - A response is popped when rsp_valid & rsp_ready.
- Occupancy and credits:
  - count = in-flight pipeline entries + queued entries, including the presented one.
  - CAP = LATENCY+1.
  - req_ready = (count < CAP); it is a registered-count function and never depends combinationally on rsp_ready or req_valid.
  - count next = count + accept − pop.
  - Sustained throughput of 1 request per cycle is required when rsp_ready is held high.
- Read timing:
  - Memory is sampled in the accept cycle.
  - The entry enters a LATENCY-stage shift pipeline (advances every cycle, never stalls), then writes into a FIFO of depth CAP.
  - With the FIFO empty, a request accepted at edge T gives rsp_valid=1 in the cycle after edge T+LATENCY−1, i.e. LATENCY cycles after accept.
  - The FIFO never overflows because of the credit limit.
- Ordering:
  - Responses are returned strictly in request order.
  - rsp_valid/rsp_data/rsp_addr/rsp_err are held stable while rsp_valid & !rsp_ready.
- Error:
  - The request is in error if req_addr[1:0]!=0 or word index req_addr>>2 >= DEPTH_WORDS.
  - An error response gives rsp_err=1 and rsp_data=0, occupies a normal slot and has normal latency.
- Flush (flush=1 at an edge):
  - All pipeline and FIFO entries are invalidated, count=0, and rsp_valid=0 next cycle.
  - A request accepted in the same cycle as flush is also dropped.
  - A pop in the flush cycle is still considered consumed.
  - req_ready=1 the cycle after flush.
- Preload:
  - ld_en writes mem[ld_addr] at the edge.
  - A fetch accepted in the same cycle to the same word returns the OLD data (read-before-write).
  - ld_en during normal traffic is legal.
- Wrap-around:
  - The address is not incremented internally.
  - Index DEPTH_WORDS−1 is valid; the next word is an error, not a wrap to 0.

Decomposition:
- Shared package (proc_pkg):
  - Constants WORD_BYTES=4 and INSTR_W=32.
  - Typedef fetch_rsp_t {data, addr, err}, reused by the fetch stage.
- One natural sub-module: rsp_fifo (parameterised depth/width, synchronous reset, push/pop, full/empty/count).
- The latency pipeline and memory array stay in the top module.

Test Plan:
- Preload mem[0..3]=32'h11,22,33,44; rsp_ready=1; requests at addr 0,4,8,12 back-to-back -> responses 11,22,33,44 in order, each LATENCY cycles after its accept, one per cycle, req_ready never drops.
- rsp_ready=0 after one response; keep requesting with LATENCY=2 -> exactly 3 requests accepted, then req_ready=0, outputs stable; raise rsp_ready -> 3 responses in order, req_ready returns 1 the cycle after the first pop.
- Request addr 0x6 and addr 0x400 (DEPTH_WORDS=256) -> both rsp_err=1, rsp_data=0, rsp_addr echoed; the following aligned request returns valid data.
- Two requests in flight, assert flush together with a third accepted request -> no responses for any of the three; the next request at addr 8 returns 33 after LATENCY.
- Same-cycle ld_en to word 1 with new value 32'hAA and fetch of addr 4 -> response 22; a fetch of addr 4 in the next cycle returns AA.
- Assert rst with 2 entries queued and rsp_ready=0 -> next cycle rsp_valid=0, req_ready=1, and no stale responses after release.
